sample_frame_feeder: RTL and testbench

//   Input stage directly upstream of the datapath/control-path top. Accepts signed
//   8-bit samples on a valid/ready port and buffers them in a FIFO. When a full

---
 rtl/sample_frame_feeder.sv | 84 ++++++++
 tb/tb_sample_frame_feeder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_frame_feeder.sv
// sample_frame_feeder: FIFO-buffered sample input that streams framed bursts with an idle gap.
// Optional SAT_CLAMP_EN: stores a written 8'h80 as 8'h81 for a symmetric sample range.
module sample_frame_feeder #(
   parameter int DEPTH      = 16,
   parameter int FRAME_LEN  = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       stream_en,
   output logic [7:0] dataina,
   output logic       out_valid,
   output logic       out_sof,
   output logic       out_eof,
   output logic [7:0] frames_sent,
   output logic       overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = $clog2(GAP_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;
   state_t state;
   logic [7:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_next, frm_cnt;
   logic [GW-1:0] gap_cnt;
   logic [7:0] wdata;
   logic wr, rd, last;
`ifdef SAT_CLAMP_EN
   assign wdata = (in_data == 8'h80) ? 8'h81 : in_data;
`else
   assign wdata = in_data;
`endif
   assign wr = in_valid && in_ready;
   assign rd = state == STREAM;
   assign last = frm_cnt == CW'(FRAME_LEN - 1);
   assign count_next = count + CW'(wr) - CW'(rd);
   always_ff @(posedge clk) if (wr) mem[wr_ptr] <= wdata;
   // Entry into STREAM guarantees a full frame is buffered, so reads never underrun.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         frm_cnt     <= '0;
         gap_cnt     <= '0;
         in_ready    <= 1'b1;
         dataina     <= '0;
         out_valid   <= 1'b0;
         out_sof     <= 1'b0;
         out_eof     <= 1'b0;
         frames_sent <= '0;
         overflow    <= 1'b0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (rd) rd_ptr <= rd_ptr + 1'b1;
         if (rd) dataina <= mem[rd_ptr];
         if (in_valid && !in_ready) overflow <= 1'b1;
         count     <= count_next;
         in_ready  <= count_next < CW'(DEPTH);
         out_valid <= rd;
         out_sof   <= rd && frm_cnt == '0;
         out_eof   <= rd && last;
         case (state)
            IDLE: if (count >= CW'(FRAME_LEN) && stream_en) begin
               state   <= STREAM;
               frm_cnt <= '0;
            end
            STREAM: if (last) begin
               state       <= GAP;
               gap_cnt     <= '0;
               frames_sent <= frames_sent + 8'd1;
            end else frm_cnt <= frm_cnt + 1'b1;
            GAP: if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= IDLE;
               else gap_cnt <= gap_cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sample_frame_feeder.sv
// tb_sample_frame_feeder: directed scenario bench for sample_frame_feeder (DEPTH=16, FRAME_LEN=8, GAP_CYCLES=2).
module tb_sample_frame_feeder;
   logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, stream_en = 1'b0;
   logic [7:0] in_data = '0;
   logic in_ready, out_valid, out_sof, out_eof, overflow;
   logic [7:0] dataina, frames_sent;
   int errors = 0, checks = 0, cyc = 0;
   typedef struct packed {logic [7:0] d; logic sof; logic eof; int c;} smp_t;
   smp_t q[$];
   sample_frame_feeder dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .stream_en(stream_en), .dataina(dataina), .out_valid(out_valid), .out_sof(out_sof),
      .out_eof(out_eof), .frames_sent(frames_sent), .overflow(overflow)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (out_valid) q.push_back('{dataina, out_sof, out_eof, cyc});
   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1);
   end
   task automatic do_reset();
      in_valid = 0; stream_en = 0; reset = 1;
      @(negedge clk); @(negedge clk);
      reset = 0;
   endtask
   task automatic put(input logic [7:0] v);
      in_data = v; in_valid = 1;
      @(negedge clk);
      in_valid = 0;
   endtask
   task automatic test_reset();
      do_reset();
      checks++;
      if ({dataina, out_valid, out_sof, out_eof, in_ready, frames_sent, overflow} !== {8'h00, 4'b0001, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got d=%h v=%b s=%b e=%b rdy=%b fs=%0d ovf=%b, want d=00 v=0 s=0 e=0 rdy=1 fs=0 ovf=0",
                  dataina, out_valid, out_sof, out_eof, in_ready, frames_sent, overflow);
      end
   endtask
   task automatic test_single_frame();
      logic [7:0] v [8] = '{8'h81, 8'h81, 8'd30, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
      logic [7:0] ed;
      logic ev;
      do_reset();
      stream_en = 1;
      for (int i = 0; i < 8; i++) put(v[i]);
      for (int j = 1; j <= 11; j++) begin
         @(negedge clk);
         ev = j >= 2 && j <= 9;
         ed = j < 2 ? 8'h00 : (j <= 9 ? v[j-2] : v[7]);
         checks++;
         if ({out_valid, out_sof, out_eof, dataina} !== {ev, j == 2, j == 9, ed}) begin
            errors++;
            $display("FAIL frame1_cycle%0d: got v=%b s=%b e=%b d=%h, want v=%b s=%b e=%b d=%h",
                     j, out_valid, out_sof, out_eof, dataina, ev, j == 2, j == 9, ed);
         end
      end
      checks++;
      if (frames_sent !== 8'd1) begin
         errors++;
         $display("FAIL frame1_count: got %0d want 1", frames_sent);
      end
      stream_en = 0;
   endtask
   task automatic test_overflow();
      int t;
      do_reset();
      q.delete();
      for (int i = 0; i < 16; i++) begin
         put(8'(i * 17 + 3));
         checks++;
         if (in_ready !== (i < 15)) begin
            errors++;
            $display("FAIL fill_ready_%0d: got %b want %b", i, in_ready, i < 15);
         end
      end
      put(8'h55);
      checks++;
      if ({overflow, in_ready} !== 2'b10) begin
         errors++;
         $display("FAIL overflow_flag: got ovf=%b rdy=%b want ovf=1 rdy=0", overflow, in_ready);
      end
      stream_en = 1;
      for (t = 0; t < 100; t++) begin
         @(negedge clk);
         if (q.size() >= 16) break;
      end
      repeat (15) @(negedge clk);
      checks++;
      if (q.size() != 16) begin
         errors++;
         $display("FAIL ovf_drain_size: got %0d samples want 16", q.size());
      end
      for (int i = 0; i < 16 && i < q.size(); i++) begin
         checks++;
         if ({q[i].d, q[i].sof, q[i].eof} !== {8'(i * 17 + 3), i % 8 == 0, i % 8 == 7}) begin
            errors++;
            $display("FAIL ovf_sample%0d: got d=%h s=%b e=%b want d=%h s=%b e=%b",
                     i, q[i].d, q[i].sof, q[i].eof, 8'(i * 17 + 3), i % 8 == 0, i % 8 == 7);
         end
         if (i % 8 != 0) begin
            checks++;
            if (q[i].c != q[i-1].c + 1) begin
               errors++;
               $display("FAIL ovf_contig%0d: got cycle %0d want %0d", i, q[i].c, q[i-1].c + 1);
            end
         end
      end
      if (q.size() >= 9) begin
         checks++;
         if (q[8].c - q[7].c <= 2) begin
            errors++;
            $display("FAIL ovf_gap: got spacing %0d want > 2", q[8].c - q[7].c);
         end
      end
      checks++;
      if ({frames_sent, overflow} !== {8'd2, 1'b1}) begin
         errors++;
         $display("FAIL ovf_end: got fs=%0d ovf=%b want fs=2 ovf=1", frames_sent, overflow);
      end
      stream_en = 0;
   endtask
   task automatic test_back_to_back();
      int t;
      do_reset();
      q.delete();
      stream_en = 1;
      in_valid = 1;
      for (int i = 0; i < 40; i++) begin
         in_data = 8'(i * 5 + 1);
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready);
         end
         @(negedge clk);
      end
      in_valid = 0;
      for (t = 0; t < 300; t++) begin
         @(negedge clk);
         if (q.size() >= 40) break;
      end
      checks++;
      if (q.size() != 40) begin
         errors++;
         $display("FAIL b2b_size: got %0d samples want 40", q.size());
      end
      for (int i = 0; i < 40 && i < q.size(); i++) begin
         checks++;
         if (q[i].d !== 8'(i * 5 + 1)) begin
            errors++;
            $display("FAIL b2b_sample%0d: got %h want %h", i, q[i].d, 8'(i * 5 + 1));
         end
      end
      checks++;
      if ({overflow, frames_sent} !== {1'b0, 8'd5}) begin
         errors++;
         $display("FAIL b2b_end: got ovf=%b fs=%0d want ovf=0 fs=5", overflow, frames_sent);
      end
      stream_en = 0;
   endtask
   task automatic test_reset_mid_stream();
      int t;
      do_reset();
      q.delete();
      stream_en = 1;
      for (int i = 0; i < 8; i++) put(8'(i + 10));
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre_reset: got out_valid=%b want 1", out_valid);
      end
      #2 reset = 1;
      #1;
      checks++;
      if ({dataina, out_valid, out_sof, out_eof, in_ready, frames_sent, overflow} !== {8'h00, 4'b0001, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL mid_async_reset: got d=%h v=%b s=%b e=%b rdy=%b fs=%0d ovf=%b",
                  dataina, out_valid, out_sof, out_eof, in_ready, frames_sent, overflow);
      end
      @(negedge clk); @(negedge clk);
      reset = 0;
      foreach (q[i]) begin
         checks++;
         if (q[i].eof !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_eof%0d: got eof=1 want 0", i);
         end
      end
      q.delete();
      for (int i = 0; i < 8; i++) put(8'(i + 50));
      for (t = 0; t < 40; t++) begin
         @(negedge clk);
         if (q.size() >= 8) break;
      end
      checks++;
      if (q.size() != 8) begin
         errors++;
         $display("FAIL mid_fresh_size: got %0d samples want 8", q.size());
      end
      for (int i = 0; i < 8 && i < q.size(); i++) begin
         checks++;
         if ({q[i].d, q[i].sof, q[i].eof} !== {8'(i + 50), i == 0, i == 7}) begin
            errors++;
            $display("FAIL mid_fresh%0d: got d=%h s=%b e=%b want d=%h s=%b e=%b",
                     i, q[i].d, q[i].sof, q[i].eof, 8'(i + 50), i == 0, i == 7);
         end
      end
      checks++;
      if (frames_sent !== 8'd1) begin
         errors++;
         $display("FAIL mid_count: got %0d want 1", frames_sent);
      end
      stream_en = 0;
   endtask
   task automatic test_clamp();
      int t;
      logic [7:0] first;
`ifdef SAT_CLAMP_EN
      first = 8'h81;
`else
      first = 8'h80;
`endif
      do_reset();
      q.delete();
      stream_en = 1;
      put(8'h80);
      for (int i = 0; i < 7; i++) put(8'h00);
      for (t = 0; t < 40; t++) begin
         @(negedge clk);
         if (q.size() >= 8) break;
      end
      checks++;
      if (q.size() != 8) begin
         errors++;
         $display("FAIL clamp_size: got %0d samples want 8", q.size());
      end
      for (int i = 0; i < 8 && i < q.size(); i++) begin
         checks++;
         if (q[i].d !== (i == 0 ? first : 8'h00)) begin
            errors++;
            $display("FAIL clamp_sample%0d: got %h want %h", i, q[i].d, i == 0 ? first : 8'h00);
         end
      end
      stream_en = 0;
   endtask
   task automatic test_frame_wrap();
      int t;
      do_reset();
      stream_en = 1;
      for (int f = 0; f < 256; f++) begin
         q.delete();
         for (int i = 0; i < 8; i++) put(8'(f));
         for (t = 0; t < 40; t++) begin
            @(negedge clk);
            if (out_eof) break;
         end
         checks++;
         if (t == 40) begin
            errors++;
            $display("FAIL wrap_timeout: no eof for frame %0d", f);
            break;
         end
         if (frames_sent !== 8'(f + 1)) begin
            errors++;
            $display("FAIL wrap_count%0d: got %0d want %0d", f, frames_sent, 8'(f + 1));
         end
      end
      stream_en = 0;
   endtask
   initial begin
      test_reset();
      test_single_frame();
      test_overflow();
      test_back_to_back();
      test_reset_mid_stream();
      test_clamp();
      test_frame_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
